// File: rtl/lcd_port_arbiter.sv
// Arbitrates several requesters onto the single LCD character-write port and runs the req/busy/done handshake.
// Define LCD_ARB_RR_EN for round-robin winner selection; otherwise fixed priority with port 0 highest.
module lcd_port_arbiter #(
   parameter int NPORT          = 3,
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input  logic                 clk,
   input  logic                 internal_rst_n,
   input  logic [NPORT-1:0]     p_req,
   input  logic [2*NPORT-1:0]   p_row,
   input  logic [4*NPORT-1:0]   p_col,
   input  logic [8*NPORT-1:0]   p_char,
   output logic [NPORT-1:0]     p_busy,
   output logic [NPORT-1:0]     p_done,
   input  logic                 lcd_busy,
   input  logic                 lcd_done,
   output logic                 lcd_req,
   output logic [1:0]           lcd_row,
   output logic [3:0]           lcd_col,
   output logic [7:0]           lcd_char,
   output logic                 timeout_pulse
);

   localparam int          GW           = (NPORT > 2) ? 2 : 1;
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

   state_t            state, state_n;
   logic [GW-1:0]     grant, grant_n, win, search_start;
   logic [31:0]       tmo_cnt, tmo_cnt_n;
   logic [NPORT-1:0]  pending, cap, clr_pend, p_done_n;
   logic              lcd_req_n, timeout_n;
   logic [1:0]        row_n;
   logic [3:0]        col_n;
   logic [7:0]        char_n;

   logic [1:0]        hold_row  [NPORT];
   logic [3:0]        hold_col  [NPORT];
   logic [7:0]        hold_char [NPORT];

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   // First pending port found when scanning upward (with wrap) from start.
   function automatic logic [GW-1:0] pick(input logic [NPORT-1:0] pend, input logic [GW-1:0] start);
      logic [GW-1:0] sel;
      logic [GW-1:0] idx;
      logic          found;
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         idx = GW'((int'(start) + i) % NPORT);
         if (!found && pend[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

`ifdef LCD_ARB_RR_EN
   logic [GW-1:0] rr_ptr;

   always_ff @(posedge clk or negedge internal_rst_n) begin
      if (!internal_rst_n)
         rr_ptr <= GW'(NPORT - 1);
      else if (state == IDLE && |pending)
         rr_ptr <= win;
   end

   assign search_start = (int'(rr_ptr) == NPORT - 1) ? '0 : rr_ptr + GW'(1);
`else
   assign search_start = '0;
`endif

   assign win = pick(pending, search_start);

   always_comb begin
      for (int k = 0; k < NPORT; k++)
         p_busy[k] = pending[k] | ((state != IDLE) && (grant == GW'(k)));
   end

   // A request is only accepted while its port is free, so held data is never overwritten.
   assign cap = p_req & ~p_busy;

   always_ff @(posedge clk) begin
      for (int k = 0; k < NPORT; k++) begin
         if (cap[k]) begin
            hold_row[k]  <= p_row[2*k +: 2];
            hold_col[k]  <= p_col[4*k +: 4];
            hold_char[k] <= p_char[8*k +: 8];
         end
      end
   end

   always_comb begin
      state_n   = state;
      grant_n   = grant;
      tmo_cnt_n = tmo_cnt;
      lcd_req_n = 1'b0;
      timeout_n = 1'b0;
      p_done_n  = '0;
      clr_pend  = '0;
      row_n     = lcd_row;
      col_n     = lcd_col;
      char_n    = lcd_char;
      case (state)
         IDLE: begin
            if (|pending) begin
               grant_n   = win;
               row_n     = hold_row[win];
               col_n     = hold_col[win];
               char_n    = hold_char[win];
               tmo_cnt_n = '0;
               state_n   = ISSUE;
            end
         end
         // No bound here: the controller may be busy with its long power-up init.
         ISSUE: begin
            if (!lcd_busy) begin
               lcd_req_n = 1'b1;
               state_n   = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            tmo_cnt_n = sat_inc(tmo_cnt);
            if (lcd_done) begin
               p_done_n[grant] = 1'b1;
               clr_pend[grant] = 1'b1;
               state_n         = IDLE;
            end else if (tmo_cnt == TIMEOUT_LAST) begin
               p_done_n[grant] = 1'b1;
               clr_pend[grant] = 1'b1;
               timeout_n       = 1'b1;
               state_n         = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge internal_rst_n) begin
      if (!internal_rst_n) begin
         state         <= IDLE;
         grant         <= '0;
         tmo_cnt       <= '0;
         pending       <= '0;
         lcd_req       <= 1'b0;
         p_done        <= '0;
         timeout_pulse <= 1'b0;
         lcd_row       <= '0;
         lcd_col       <= '0;
         lcd_char      <= '0;
      end else begin
         state         <= state_n;
         grant         <= grant_n;
         tmo_cnt       <= tmo_cnt_n;
         pending       <= (pending & ~clr_pend) | cap;
         lcd_req       <= lcd_req_n;
         p_done        <= p_done_n;
         timeout_pulse <= timeout_n;
         lcd_row       <= row_n;
         lcd_col       <= col_n;
         lcd_char      <= char_n;
      end
   end

endmodule
